// File: rtl/axi_arb_pkg.sv
// Shared types and helpers for the AXI burst arbiter: FSM state encoding and
// the wrapping round-robin pointer increment.
package axi_arb_pkg;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

  // Wrapping increment that stays correct when n is not a power of two.
  function automatic int unsigned rr_next(input int unsigned ptr, input int unsigned n);
    if (ptr + 1 >= n) begin
      return 0;
    end
    return ptr + 1;
  endfunction

endpackage

// File: rtl/axi_rr_prio_enc.sv
// Combinational rotate-priority encoder: picks the first set request bit
// searching upward from ptr_i and wrapping modulo N_IN.
module axi_rr_prio_enc
  import axi_arb_pkg::*;
#(
  parameter int N_IN      = 4,
  parameter int SEL_WIDTH = (N_IN > 1) ? $clog2(N_IN) : 1
) (
  input  logic [N_IN-1:0]      req_i,
  input  logic [SEL_WIDTH-1:0] ptr_i,
  output logic [SEL_WIDTH-1:0] winner_o,
  output logic                 any_o
);

  // Walk the offsets from farthest to nearest so the nearest requester
  // relative to the pointer is the last (and therefore winning) assignment.
  always_comb begin
    int idx;
    winner_o = '0;
    any_o    = |req_i;
    idx      = 0;
    for (int off = N_IN - 1; off >= 0; off--) begin
      idx = int'(ptr_i) + off;
      if (idx >= N_IN) begin
        idx = idx - N_IN;
      end
      if (req_i[idx]) begin
        winner_o = SEL_WIDTH'(idx);
      end
    end
  end

endmodule

// File: rtl/axi_burst_arbiter.sv
// Round-robin burst arbiter: locks one requester onto the shared beat channel
// from its first beat until a LAST beat is accepted, then frees the channel.
module axi_burst_arbiter
  import axi_arb_pkg::*;
#(
  parameter int N_IN      = 4,
  parameter int SEL_WIDTH = (N_IN > 1) ? $clog2(N_IN) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_IN-1:0]      req_i,
  input  logic [N_IN-1:0]      last_i,
  output logic [N_IN-1:0]      gnt_o,
  output logic [SEL_WIDTH-1:0] sel_o,
  output logic                 out_valid_o,
  output logic                 out_last_o,
  input  logic                 out_ready_i,
  output logic                 busy_o
);

  arb_state_e           state_q, state_d;
  logic [SEL_WIDTH-1:0] sel_q, sel_d;
  logic [SEL_WIDTH-1:0] rr_ptr_q, rr_ptr_d;

  logic [SEL_WIDTH-1:0] winner;
  logic                 any_req;
  logic                 locked;
  logic                 last_handshake;

  axi_rr_prio_enc #(
    .N_IN      (N_IN),
    .SEL_WIDTH (SEL_WIDTH)
  ) u_prio_enc (
    .req_i    (req_i),
    .ptr_i    (rr_ptr_q),
    .winner_o (winner),
    .any_o    (any_req)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ARB_IDLE;
      sel_q    <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  assign locked         = (state_q == ARB_LOCKED);
  assign last_handshake = locked & req_i[sel_q] & last_i[sel_q] & out_ready_i;

  // The pointer only moves on a new grant, so a stalled or violating burst
  // never disturbs the rotation order.
  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    rr_ptr_d = rr_ptr_q;
    case (state_q)
      ARB_IDLE: begin
        if (any_req) begin
          state_d  = ARB_LOCKED;
          sel_d    = winner;
          rr_ptr_d = SEL_WIDTH'(rr_next(32'(winner), N_IN));
        end
      end
      ARB_LOCKED: begin
        if (last_handshake) begin
          state_d = ARB_IDLE;
        end
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

  always_comb begin
    gnt_o = '0;
    for (int k = 0; k < N_IN; k++) begin
      gnt_o[k] = locked & (sel_q == SEL_WIDTH'(k)) & out_ready_i;
    end
  end

  assign out_valid_o = locked & req_i[sel_q];
  assign out_last_o  = locked & last_i[sel_q];
  assign busy_o      = locked;
  assign sel_o       = sel_q;

endmodule

// File: tb/tb_axi_burst_arbiter.sv
// Self-checking bench for axi_burst_arbiter: directed scenarios plus random
// traffic compared cycle by cycle against a burst-level reference model.
module tb_axi_burst_arbiter;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] req, last, gnt;
  logic [1:0]   sel;
  logic         out_valid, out_last, out_ready, busy;

  logic [2:0]   req3, last3, gnt3;
  logic [1:0]   sel3;
  logic         out_valid3, out_last3, busy3;

  int errors = 0;
  int checks = 0;

  // Reference model state: whether a burst is locked, who owns it, next start.
  bit m_locked;
  int m_owner;
  int m_ptr;
  bit prev_busy;
  int grant_log[$];

  always #5 clk = ~clk;

  axi_burst_arbiter #(.N_IN(N)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_i       (req),
    .last_i      (last),
    .gnt_o       (gnt),
    .sel_o       (sel),
    .out_valid_o (out_valid),
    .out_last_o  (out_last),
    .out_ready_i (out_ready),
    .busy_o      (busy)
  );

  axi_burst_arbiter #(.N_IN(3)) dut3 (
    .clk         (clk),
    .rst         (rst),
    .req_i       (req3),
    .last_i      (last3),
    .gnt_o       (gnt3),
    .sel_o       (sel3),
    .out_valid_o (out_valid3),
    .out_last_o  (out_last3),
    .out_ready_i (out_ready),
    .busy_o      (busy3)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int pickWinner(input logic [N-1:0] r, input int p, input int n);
    for (int i = 0; i < n; i++) begin
      int idx;
      idx = (p + i) % n;
      if (r[idx]) return idx;
    end
    return -1;
  endfunction

  // One clock cycle: drive inputs on the falling edge, compare outputs against
  // the model's current state, then advance the model across the rising edge.
  task automatic applyStimulus(input logic [N-1:0] r, input logic [N-1:0] l,
                               input logic rdy, input logic rs);
    logic [N-1:0] exp_gnt;
    @(negedge clk);
    req = r; last = l; out_ready = rdy; rst = rs;
    #1;
    exp_gnt = (m_locked && rdy) ? (N'(1) << m_owner) : '0;
    checkOutput("busy", busy, m_locked);
    checkOutput("sel", sel, m_owner);
    checkOutput("gnt", gnt, exp_gnt);
    checkOutput("valid", out_valid, m_locked && r[m_owner]);
    checkOutput("last", out_last, m_locked && l[m_owner]);
    if (busy && !prev_busy) grant_log.push_back(int'(sel));
    prev_busy = busy;
    @(posedge clk);
    if (rs) begin
      m_locked = 0; m_owner = 0; m_ptr = 0;
    end else if (!m_locked) begin
      if (r != 0) begin
        m_owner  = pickWinner(r, m_ptr, N);
        m_ptr    = (m_owner + 1) % N;
        m_locked = 1;
      end
    end else if (r[m_owner] && l[m_owner] && rdy) begin
      m_locked = 0;
    end
  endtask

  initial begin
    req = '0; last = '0; out_ready = 1'b0; rst = 1'b1;
    req3 = '0; last3 = '0;
    m_locked = 0; m_owner = 0; m_ptr = 0; prev_busy = 0;
    repeat (2) @(posedge clk);

    // Idle after reset.
    repeat (5) applyStimulus('0, '0, 1'b1, 1'b0);

    // Three-beat burst from requester 2, then the bubble.
    applyStimulus(4'b0100, 4'b0000, 1'b1, 1'b0);
    applyStimulus(4'b0100, 4'b0000, 1'b1, 1'b0);
    applyStimulus(4'b0100, 4'b0000, 1'b1, 1'b0);
    applyStimulus(4'b0100, 4'b0100, 1'b1, 1'b0);
    applyStimulus(4'b0000, 4'b0000, 1'b1, 1'b0);
    checkOutput("grant_req2", grant_log.size() == 1 ? grant_log[0] : -1, 2);

    // Pointer sits at 3: a single beat from 3 returns it to 0.
    applyStimulus(4'b1000, 4'b1000, 1'b1, 1'b0);
    applyStimulus(4'b1000, 4'b1000, 1'b1, 1'b0);
    checkOutput("ptr_after_req2", grant_log.size() == 2 ? grant_log[1] : -1, 3);

    // All requesters active with single-beat bursts: rotation 0,1,2,3,0.
    grant_log.delete();
    repeat (10) applyStimulus(4'b1111, 4'b1111, 1'b1, 1'b0);
    checkOutput("rotate_count", grant_log.size(), 5);
    if (grant_log.size() == 5) begin
      checkOutput("rotate_0", grant_log[0], 0);
      checkOutput("rotate_1", grant_log[1], 1);
      checkOutput("rotate_2", grant_log[2], 2);
      checkOutput("rotate_3", grant_log[3], 3);
      checkOutput("rotate_4", grant_log[4], 0);
    end

    // Back-pressure while locked on requester 1.
    applyStimulus(4'b0000, 4'b0000, 1'b1, 1'b0);
    applyStimulus(4'b0010, 4'b0000, 1'b1, 1'b0);
    repeat (4) applyStimulus(4'b0010, 4'b0010, 1'b0, 1'b0);
    applyStimulus(4'b0010, 4'b0010, 1'b1, 1'b0);
    applyStimulus(4'b0000, 4'b0000, 1'b1, 1'b0);

    // Reset mid-burst on requester 3 while requester 0 waits.
    grant_log.delete();
    applyStimulus(4'b1000, 4'b0000, 1'b1, 1'b0);
    applyStimulus(4'b1000, 4'b0000, 1'b1, 1'b0);
    applyStimulus(4'b1001, 4'b0000, 1'b1, 1'b0);
    applyStimulus(4'b1001, 4'b0000, 1'b1, 1'b1);
    applyStimulus(4'b0001, 4'b0000, 1'b1, 1'b0);
    applyStimulus(4'b0001, 4'b0001, 1'b1, 1'b0);
    checkOutput("post_reset_grant", grant_log.size() == 2 ? grant_log[1] : -1, 0);

    // Random traffic, including protocol-violating request drops and resets.
    for (int c = 0; c < 600; c++) begin
      applyStimulus(N'($urandom_range(0, 15)), N'($urandom_range(0, 15)),
                    ($urandom_range(0, 3) != 0), ($urandom_range(0, 60) == 0));
    end

    // Three-requester instance: drive pointer to 2, then check the wrap.
    @(negedge clk);
    req = '0; last = '0; out_ready = 1'b1; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; req3 = 3'b010; last3 = 3'b010;
    #1 checkOutput("n3_idle", busy3, 1'b0);
    @(negedge clk);
    #1;
    checkOutput("n3_busy_1", busy3, 1'b1);
    checkOutput("n3_sel_1", sel3, 2'd1);
    checkOutput("n3_gnt_1", gnt3, 3'b010);
    @(negedge clk);
    #1 checkOutput("n3_bubble", busy3, 1'b0);
    req3 = 3'b011; last3 = 3'b011;
    @(negedge clk);
    #1;
    checkOutput("n3_sel_wrap", sel3, 2'd0);
    checkOutput("n3_gnt_wrap", gnt3, 3'b001);
    @(negedge clk);
    #1 checkOutput("n3_bubble2", busy3, 1'b0);
    @(negedge clk);
    #1;
    checkOutput("n3_sel_next", sel3, 2'd1);
    checkOutput("n3_gnt_next", gnt3, 3'b010);
    req3 = '0; last3 = '0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
